// File: rtl/freq_sweep_ctrl.sv
// Frequency-sweep sequencer for the phase-accumulator sine generator.
// Steps the tuning word from a start value toward a stop value, holding each value for a programmable dwell.
module freq_sweep_ctrl #(
    parameter int FW = 16,
    parameter int DW = 24
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_start,
    input  logic          i_stop,
    input  logic [1:0]    i_mode,
    input  logic [FW-1:0] i_f_start,
    input  logic [FW-1:0] i_f_stop,
    input  logic [FW-1:0] i_f_step,
    input  logic [DW-1:0] i_dwell,
    output logic [FW-1:0] o_freq_control,
    output logic          o_busy,
    output logic          o_step_stb,
    output logic          o_wrap_stb,
    output logic          o_done
);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    localparam logic [1:0] M_SINGLE = 2'b00;
    localparam logic [1:0] M_SAW    = 2'b01;
    localparam logic [1:0] M_TRI    = 2'b10;

    state_t        r_state, w_state_next;
    logic [FW-1:0] r_freq, w_freq_next;
    logic          r_busy, w_busy_next;
    logic          r_step_stb, w_step_stb_next;
    logic          r_wrap_stb, w_wrap_stb_next;
    logic          r_done, w_done_next;
    logic [FW-1:0] r_f_start, w_f_start_next;
    logic [FW-1:0] r_tgt, w_tgt_next;
    logic [FW-1:0] r_other, w_other_next;
    logic [FW-1:0] r_step, w_step_next;
    logic [DW-1:0] r_dwell_m1, w_dwell_m1_next;
    logic [DW-1:0] r_cnt, w_cnt_next;
    logic          r_up, w_up_next;
    logic [1:0]    r_mode, w_mode_next;

    logic [DW-1:0] w_dwell_m1_in;
    logic [FW-1:0] w_advance;
    logic [FW-1:0] w_reverse;

    // One step toward tgt in FW+1 bits; a zero step jumps straight to tgt.
    function automatic logic [FW-1:0] f_advance(
        input logic [FW-1:0] cur,
        input logic [FW-1:0] tgt,
        input logic [FW-1:0] step,
        input logic          up
    );
        logic [FW:0]   sum;
        logic [FW:0]   diff;
        logic [FW-1:0] res;
        sum  = {1'b0, cur} + {1'b0, step};
        diff = {1'b0, cur} - {1'b0, step};
        if (step == '0)
            res = tgt;
        else if (up)
            res = (sum >= {1'b0, tgt}) ? tgt : sum[FW-1:0];
        else
            res = (diff[FW] || (diff[FW-1:0] <= tgt)) ? tgt : diff[FW-1:0];
        return res;
    endfunction

    assign w_dwell_m1_in = (i_dwell == '0) ? '0 : i_dwell - 1'b1;
    assign w_advance     = f_advance(r_freq, r_tgt, r_step, r_up);
    assign w_reverse     = f_advance(r_freq, r_other, r_step, ~r_up);

    always_comb begin
        w_state_next    = r_state;
        w_freq_next     = r_freq;
        w_busy_next     = r_busy;
        w_step_stb_next = 1'b0;
        w_wrap_stb_next = 1'b0;
        w_done_next     = 1'b0;
        w_f_start_next  = r_f_start;
        w_tgt_next      = r_tgt;
        w_other_next    = r_other;
        w_step_next     = r_step;
        w_dwell_m1_next = r_dwell_m1;
        w_cnt_next      = r_cnt;
        w_up_next       = r_up;
        w_mode_next     = r_mode;

        if (i_stop) begin
            // stop outranks a coincident start, even from IDLE
            if (r_state == S_RUN) begin
                w_state_next = S_IDLE;
                w_busy_next  = 1'b0;
            end
        end else if (i_start) begin
            w_state_next    = S_RUN;
            w_freq_next     = i_f_start;
            w_busy_next     = 1'b1;
            w_step_stb_next = 1'b1;
            w_f_start_next  = i_f_start;
            w_tgt_next      = i_f_stop;
            w_other_next    = i_f_start;
            w_step_next     = i_f_step;
            w_dwell_m1_next = w_dwell_m1_in;
            w_cnt_next      = w_dwell_m1_in;
            w_up_next       = (i_f_stop >= i_f_start);
            w_mode_next     = (i_mode == 2'b11) ? M_SINGLE : i_mode;
        end else if (r_state == S_RUN) begin
            if (r_cnt != '0) begin
                w_cnt_next = r_cnt - 1'b1;
            end else begin
                w_cnt_next = r_dwell_m1;
                if (r_freq != r_tgt) begin
                    w_freq_next     = w_advance;
                    w_step_stb_next = 1'b1;
                end else begin
                    case (r_mode)
                        M_SAW: begin
                            w_freq_next     = r_f_start;
                            w_step_stb_next = 1'b1;
                            w_wrap_stb_next = 1'b1;
                        end
                        M_TRI: begin
                            w_tgt_next      = r_other;
                            w_other_next    = r_tgt;
                            w_up_next       = ~r_up;
                            w_freq_next     = w_reverse;
                            w_step_stb_next = 1'b1;
                            w_wrap_stb_next = 1'b1;
                        end
                        default: begin
                            w_state_next = S_IDLE;
                            w_busy_next  = 1'b0;
                            w_done_next  = 1'b1;
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= S_IDLE;
            r_freq     <= '0;
            r_busy     <= 1'b0;
            r_step_stb <= 1'b0;
            r_wrap_stb <= 1'b0;
            r_done     <= 1'b0;
            r_f_start  <= '0;
            r_tgt      <= '0;
            r_other    <= '0;
            r_step     <= '0;
            r_dwell_m1 <= '0;
            r_cnt      <= '0;
            r_up       <= 1'b0;
            r_mode     <= M_SINGLE;
        end else begin
            r_state    <= w_state_next;
            r_freq     <= w_freq_next;
            r_busy     <= w_busy_next;
            r_step_stb <= w_step_stb_next;
            r_wrap_stb <= w_wrap_stb_next;
            r_done     <= w_done_next;
            r_f_start  <= w_f_start_next;
            r_tgt      <= w_tgt_next;
            r_other    <= w_other_next;
            r_step     <= w_step_next;
            r_dwell_m1 <= w_dwell_m1_next;
            r_cnt      <= w_cnt_next;
            r_up       <= w_up_next;
            r_mode     <= w_mode_next;
        end
    end

    assign o_freq_control = r_freq;
    assign o_busy         = r_busy;
    assign o_step_stb     = r_step_stb;
    assign o_wrap_stb     = r_wrap_stb;
    assign o_done         = r_done;

endmodule

// File: tb/tb_freq_sweep_ctrl.sv
// Self-checking bench for freq_sweep_ctrl: directed and random sweeps against a value-list reference model.
module tb_freq_sweep_ctrl;
    localparam int FW = 16;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic [FW-1:0] f_start = '0;
    logic [FW-1:0] f_stop = '0;
    logic [FW-1:0] f_step = '0;
    logic [DW-1:0] dwell = '0;
    logic [FW-1:0] freq_control;
    logic          busy, step_stb, wrap_stb, done;

    int            checks = 0;
    int            failures = 0;
    int            sweep_id = 0;
    logic [FW-1:0] last_freq = '0;

    freq_sweep_ctrl #(.FW(FW), .DW(DW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_stop         (stop),
        .i_mode         (mode),
        .i_f_start      (f_start),
        .i_f_stop       (f_stop),
        .i_f_step       (f_step),
        .i_dwell        (dwell),
        .o_freq_control (freq_control),
        .o_busy         (busy),
        .o_step_stb     (step_stb),
        .o_wrap_stb     (wrap_stb),
        .o_done         (done)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [FW+3:0] obs, input logic [FW+3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [FW+3:0] outs();
        return {freq_control, busy, step_stb, wrap_stb, done};
    endfunction

    // Spec stepping rule on plain integers: no width tricks needed for overflow.
    function automatic int model_step(input int v, input int tgt, input int st, input bit up);
        int n;
        if (st == 0) return tgt;
        if (up) begin
            n = v + st;
            return (n >= tgt) ? tgt : n;
        end
        n = v - st;
        return (n <= tgt) ? tgt : n;
    endfunction

    // Called at a negedge; issues start, then checks n cycles against the model.
    task automatic run_sweep(input logic [1:0] m, input int fs, input int fe, input int st,
                             input int dw, input int max_cyc, input bit end_stop);
        int   vals[$];
        bit   wr[$];
        int   em, d, k, a, b, v, t, n_cyc, full, idx, ef;
        bit   up, eb, es, ew, ed;
        logic [FW-1:0] efv;
        sweep_id++;
        em = (m == 2'b11) ? 0 : int'(m);
        d  = (dw == 0) ? 1 : dw;
        a = fs; b = fe; up = (fe >= fs); v = fs;
        vals.push_back(v); wr.push_back(1'b0);
        while (vals.size() < 200) begin
            if (v == b) begin
                if (em == 0) break;
                if (em == 1) v = fs;
                else begin
                    t = a; a = b; b = t; up = !up;
                    v = model_step(v, b, st, up);
                end
                vals.push_back(v); wr.push_back(1'b1);
            end else begin
                v = model_step(v, b, st, up);
                vals.push_back(v); wr.push_back(1'b0);
            end
        end
        k     = vals.size();
        full  = (em == 0) ? k * d + 3 : 0;
        n_cyc = (max_cyc > 0 && (em != 0 || max_cyc < full)) ? max_cyc : full;
        $display("sweep %0d mode=%0d fs=%h fe=%h step=%h dwell=%0d cycles=%0d stop=%0d",
                 sweep_id, m, fs[FW-1:0], fe[FW-1:0], st[FW-1:0], dw, n_cyc, end_stop);

        mode = m; f_start = fs[FW-1:0]; f_stop = fe[FW-1:0]; f_step = st[FW-1:0]; dwell = dw[DW-1:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // configuration changes during RUN must be ignored
        mode = 2'($urandom); f_start = FW'($urandom); f_stop = FW'($urandom);
        f_step = FW'($urandom); dwell = DW'($urandom_range(0, 7));
        for (int c = 0; c < n_cyc; c++) begin
            if (c > 0) @(negedge clk);
            idx = c / d;
            if (em == 0 && idx >= k) begin
                ef = vals[k-1]; eb = 0; es = 0; ew = 0; ed = (c == k * d);
            end else begin
                ef = vals[idx]; eb = 1; es = (c % d == 0); ew = es && wr[idx]; ed = 0;
            end
            efv = ef[FW-1:0];
            last_freq = efv;
            check($sformatf("sweep%0d_c%0d", sweep_id, c), outs(), {efv, eb, es, ew, ed});
        end
        if (end_stop) begin
            stop = 1'b1;
            @(negedge clk);
            stop = 1'b0;
            for (int c = 0; c < 3; c++) begin
                if (c > 0) @(negedge clk);
                check($sformatf("sweep%0d_stop%0d", sweep_id, c), outs(), {last_freq, 4'b0000});
            end
        end
    endtask

    initial begin
        int m, fs, fe, st, dw, rng;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", outs(), '0);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("idle_no_start%0d", c), outs(), '0);
        end

        run_sweep(2'b00, 100, 130, 10, 4, 0, 1'b0);
        run_sweep(2'b00, 'h20, 'h05, 'h0A, 0, 0, 1'b0);
        run_sweep(2'b00, 'hFFF0, 'hFFFF, 'h20, 1, 0, 1'b0);
        run_sweep(2'b00, 'h0010, 'h0000, 'h30, 2, 0, 1'b0);
        run_sweep(2'b10, 0, 20, 10, 2, 24, 1'b1);
        run_sweep(2'b01, 10, 40, 15, 3, 30, 1'b1);
        run_sweep(2'b00, 50, 500, 0, 3, 0, 1'b0);
        run_sweep(2'b01, 7, 7, 5, 2, 10, 1'b1);
        run_sweep(2'b10, 7, 7, 5, 0, 6, 1'b1);
        run_sweep(2'b11, 3, 9, 3, 1, 0, 1'b0);

        // restart exactly on the edge that would have produced done
        run_sweep(2'b00, 5, 8, 3, 2, 4, 1'b0);
        run_sweep(2'b00, 200, 180, 10, 1, 0, 1'b0);

        // simultaneous start and stop during RUN: stop wins, no restart
        run_sweep(2'b10, 1000, 1040, 20, 2, 9, 1'b0);
        mode = 2'b00; f_start = 16'h1234; f_stop = 16'h2000; f_step = 16'h0001; dwell = 24'd1;
        start = 1'b1; stop = 1'b1;
        @(negedge clk);
        start = 1'b0; stop = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) @(negedge clk);
            check($sformatf("start_stop%0d", c), outs(), {last_freq, 4'b0000});
        end

        // asynchronous reset mid-sweep
        @(negedge clk);
        run_sweep(2'b01, 300, 400, 25, 2, 7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle%0d", c), outs(), '0);
        end

        for (int i = 0; i < 24; i++) begin
            m   = $urandom_range(0, 3);
            fs  = $urandom_range(0, 65535);
            fe  = (i % 3 == 0) ? $urandom_range(65500, 65535) : $urandom_range(0, 65535);
            rng = (fe > fs) ? fe - fs : fs - fe;
            st  = ($urandom_range(0, 9) == 0) ? 0 : rng / $urandom_range(1, 5) + $urandom_range(0, 3);
            if (st > 65535) st = 65535;
            dw  = $urandom_range(0, 3);
            if (m == 0 || m == 3) run_sweep(m[1:0], fs, fe, st, dw, 0, 1'b0);
            else                  run_sweep(m[1:0], fs, fe, st, dw, 40, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/freq_sweep_ctrl.md
# freq_sweep_ctrl

Programmable frequency-sweep sequencer that drives the 16-bit `freq_control` word of the downstream phase-accumulator sine generator. It steps the tuning word from a start value toward a stop value in fixed increments, holding each value for a programmable dwell. It supports single-shot, sawtooth-repeat and triangle sweeps, and is used for frequency-response and chirp test modes on the 125 MHz DAC clock domain.

## Interface
- `FW`, 16: tuning-word width; matches the sine generator's `freq_control`.
- `DW`, 24: dwell counter width.
- `clk`  in  1  125 MHz system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; latches configuration and begins the sweep.
- `stop`  in  1  one-cycle pulse; aborts the sweep.
- `mode`  in  2  sweep mode: 00 single, 01 sawtooth repeat, 10 triangle repeat, 11 treated as 00.
- `f_start`  in  FW  first tuning word.
- `f_stop`  in  FW  last tuning word.
- `f_step`  in  FW  unsigned increment magnitude.
- `dwell`  in  DW  cycles each tuning word is held; 0 is treated as 1.
- `freq_control`  out  FW  registered tuning word to the sine generator.
- `busy`  out  1  high while a sweep is active.
- `step_stb`  out  1  one-cycle pulse on every cycle `freq_control` takes a new value.
- `wrap_stb`  out  1  one-cycle pulse when a repeat mode restarts or reverses.
- `done`  out  1  one-cycle pulse at the end of a single sweep.

## Operation
- Reset values: `freq_control` = 0, `busy` = 0, `step_stb` = 0, `wrap_stb` = 0, `done` = 0, state = IDLE.
- States are IDLE and RUN.
- `start` (in any state) latches `f_start`, `f_stop`, `f_step`, `dwell` and `mode` into shadow registers. It then sets `freq_control` = `f_start`, `busy` = 1, `step_stb` = 1, loads the dwell counter, and moves to RUN.
- Input changes during RUN have no effect until the next `start`.
- Direction is fixed at `start`: up if `f_stop` >= `f_start`, otherwise down.
- RUN: the dwell counter decrements each cycle. When it expires, the block computes the next tuning word in FW+1 bits:
  - up: `cur` + `step`, clamped to `f_stop` if the result is >= `f_stop` or overflows;
  - down: `cur` − `step`, clamped to `f_stop` if the result is <= `f_stop` or underflows.
- `f_step` = 0 is treated as a single jump to `f_stop`.
- Endpoint: when `freq_control` already equals the target endpoint and its dwell expires, the action depends on mode:
  - single: `done` = 1 for one cycle, `busy` = 0, go to IDLE. `freq_control` holds the endpoint value until the next `start`.
  - sawtooth: `freq_control` reloads `f_start`, `wrap_stb` = 1 and `step_stb` = 1.
  - triangle: swap the endpoints, invert direction, then step by `f_step` from the current value with the same clamping rule. Assert `wrap_stb` = 1 and `step_stb` = 1.
- `f_start` == `f_stop`: the value is held for one dwell, then the endpoint rule applies (single → `done`; repeat modes re-present the same value each dwell with `wrap_stb`).
- `stop`: go to IDLE, `busy` = 0, `freq_control` frozen at its current value, no `done`.
- `stop` and `start` in the same cycle: `stop` wins.
- `stop` in IDLE: no effect.
- `start` during RUN restarts cleanly. Any `done` or `wrap_stb` that would have fired in that same cycle is suppressed.
- Asynchronous reset mid-sweep returns all outputs to their reset values immediately.

## Timing
- `start` sampled at edge n → `freq_control` = `f_start`, `busy` = 1 and `step_stb` = 1 after edge n.
- Every tuning word is held for exactly max(`dwell`, 1) cycles. `step_stb` asserts in the first cycle of each new value.
- `done` / `wrap_stb` assert in the same cycle the endpoint's dwell expires. `busy` falls in that same cycle for single mode.
- Single sweep of K distinct values (including both endpoints) takes K·max(`dwell`, 1) cycles from `start` to `done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset then idle: assert `rst_n` = 0 mid-run → all outputs 0 in the same cycle. Release `rst_n`, apply no `start` → outputs stay 0.
- Single up sweep: `f_start` = 100, `f_stop` = 130, `f_step` = 10, `dwell` = 4 → `freq_control` = 100/110/120/130, each held 4 cycles, 4 `step_stb` pulses, `done` 16 cycles after `start`, `freq_control` stays 130.
- Clamp and down sweep: `f_start` = 0x0020, `f_stop` = 0x0005, `f_step` = 0x000A, `dwell` = 0 → 0x20, 0x16, 0x0C, 0x05, one cycle each, then `done`.
- Overflow clamp: `f_start` = 0xFFF0, `f_stop` = 0xFFFF, `f_step` = 0x0020 → 0xFFF0 then 0xFFFF; no wrap to a low value.
- Triangle: `mode` = 10, `f_start` = 0, `f_stop` = 20, `f_step` = 10, `dwell` = 2 → 0,10,20,10,0,10,… with `wrap_stb` on entry to each 10 following an endpoint and `busy` held high. `stop` → output frozen and `busy` = 0 next cycle.
- Simultaneous `start` and `stop` during RUN → IDLE, no restart. `start` alone during RUN → `freq_control` = new `f_start` next cycle, no `done`.
